// File: rtl/tdc_multi_if.sv
// AXI-Stream record channel between the TDC and its consumer.
interface tdc_multi_if #(
    parameter int unsigned DATA_WIDTH = 321
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/tdc_multi.sv
// Multi-channel TDC: per-gate first/last edge timestamps and edge counts,
// emitted as one packed AXI-Stream record per gate with an overrun flag.
module tdc_multi #(
    parameter int unsigned COUNTER_WIDTH  = 32,
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned EDGE_CNT_WIDTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_s0,
    input  logic [NUM_CH-1:0] i_s1,
    tdc_multi_if.master       m_axis
);
    localparam int unsigned CH_W       = 2 * COUNTER_WIDTH + EDGE_CNT_WIDTH;
    localparam int unsigned DATA_WIDTH = COUNTER_WIDTH + NUM_CH * CH_W + 1;

    logic [COUNTER_WIDTH-1:0]                  cnt_q;
    logic [NUM_CH-1:0][COUNTER_WIDTH-1:0]      t1_q;
    logic [NUM_CH-1:0][COUNTER_WIDTH-1:0]      t2_q;
    logic [NUM_CH-1:0][EDGE_CNT_WIDTH-1:0]     n_q;
    logic [NUM_CH-1:0]                         v_q;
    logic [DATA_WIDTH-1:0]                     rec_q;
    logic                                      tvalid_q;

    logic [NUM_CH-1:0][EDGE_CNT_WIDTH-1:0]     n_inc_c;
    logic [NUM_CH-1:0][COUNTER_WIDTH-1:0]      cap_t1_c;
    logic [NUM_CH-1:0][COUNTER_WIDTH-1:0]      cap_t2_c;
    logic [NUM_CH-1:0][EDGE_CNT_WIDTH-1:0]     cap_n_c;
    logic [DATA_WIDTH-1:0]                     rec_c;

    // Saturating edge-count increment and the closing-period values per channel.
    always_comb begin
        n_inc_c  = '0;
        cap_t1_c = '0;
        cap_t2_c = '0;
        cap_n_c  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            n_inc_c[k] = (n_q[k] == {EDGE_CNT_WIDTH{1'b1}}) ? n_q[k]
                                                            : n_q[k] + EDGE_CNT_WIDTH'(1);
            if (i_s1[k]) begin
                // A coincident edge still belongs to the period being closed.
                cap_t1_c[k] = v_q[k] ? t1_q[k] : cnt_q;
                cap_t2_c[k] = cnt_q;
                cap_n_c[k]  = v_q[k] ? n_inc_c[k] : EDGE_CNT_WIDTH'(1);
            end else if (v_q[k]) begin
                cap_t1_c[k] = t1_q[k];
                cap_t2_c[k] = t2_q[k];
                cap_n_c[k]  = n_q[k];
            end else begin
                cap_t1_c[k] = {COUNTER_WIDTH{1'b1}};
                cap_t2_c[k] = {COUNTER_WIDTH{1'b1}};
                cap_n_c[k]  = '0;
            end
        end
    end

    // Record packing: T0 in the LSBs, channels above it, overrun in the MSB.
    always_comb begin
        rec_c                     = '0;
        rec_c[COUNTER_WIDTH-1:0]  = cnt_q;
        for (int k = 0; k < NUM_CH; k++) begin
            rec_c[COUNTER_WIDTH + k * CH_W +: CH_W] = {cap_n_c[k], cap_t2_c[k], cap_t1_c[k]};
        end
        rec_c[DATA_WIDTH-1]       = tvalid_q & ~m_axis.tready;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q    <= '0;
            t1_q     <= '0;
            t2_q     <= '0;
            n_q      <= '0;
            v_q      <= '0;
            rec_q    <= '0;
            tvalid_q <= 1'b0;
        end else begin
            if (i_s0) begin
                cnt_q <= '0;
            end else if (cnt_q != {COUNTER_WIDTH{1'b1}}) begin
                cnt_q <= cnt_q + COUNTER_WIDTH'(1);
            end

            if (i_s0) begin
                t1_q <= '0;
                t2_q <= '0;
                n_q  <= '0;
                v_q  <= '0;
            end else begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (i_s1[k]) begin
                        if (!v_q[k]) begin
                            t1_q[k] <= cnt_q;
                        end
                        t2_q[k] <= cnt_q;
                        v_q[k]  <= 1'b1;
                        n_q[k]  <= n_inc_c[k];
                    end
                end
            end

            if (i_s0) begin
                rec_q <= rec_c;
            end

            // Gate wins over the consumer's ready.
            if (i_s0) begin
                tvalid_q <= 1'b1;
            end else if (m_axis.tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign m_axis.tdata  = rec_q;
    assign m_axis.tvalid = tvalid_q;
endmodule
